mult_err_monitor: RTL and testbench
===================================

MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the sample and mismatch counters.
REQ-002 SHALL have parameter SUM_W, default 40: width of the error-distance accumulator.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle pulse; clears statistics and begins a run.
REQ-006 SHALL have port stop, input, 1: one-cycle pulse; ends the run early.
REQ-007 SHALL have port cfg_num, input, CNT_W: samples per run; 0 means run until stop.
REQ-008 SHALL have port in_valid, input, 1: sample present.
REQ-009 SHALL have port in_ready, output, 1: monitor accepts a sample.
REQ-010 SHALL have port a, input, 8: multiplier operand A.
REQ-011 SHALL have port b, input, 8: multiplier operand B.
REQ-012 SHALL have port p_approx, input, 16: product under test for (a, b).
REQ-013 SHALL have port busy, output, 1: high in RUN and DRAIN.
REQ-014 SHALL have port done, output, 1: high in DONE.
REQ-015 SHALL have port n_samples, output, CNT_W: accepted sample count.
REQ-016 SHALL have port n_mismatch, output, CNT_W: count of samples with p_approx not equal to a*b.
REQ-017 SHALL have port sum_ed, output, SUM_W: sum of error distances |p_approx - a*b|.
REQ-018 SHALL have port max_ed, output, 16: largest error distance seen.
REQ-019 SHALL have port max_a, output, 8: A operand of the first sample reaching max_ed.
REQ-020 SHALL have port max_b, output, 8: B operand of the first sample reaching max_ed.

Function
REQ-021 SHALL implement FSM IDLE->RUN on start; RUN->DRAIN on stop or on acceptance of sample cfg_num (cfg_num!=0); DRAIN->DONE when the pipeline is empty; DONE->RUN on start.
REQ-022 SHALL ignore start while in RUN or DRAIN, and ignore stop outside RUN.
REQ-023 SHALL clear all statistics outputs in the cycle it enters RUN.
REQ-024 SHALL drive in_ready high only in RUN; a sample is accepted when in_valid and in_ready are both high.
REQ-025 SHALL use a 2-stage pipeline: stage 1 registers the exact 16-bit product and the operands; stage 2 computes the 17-bit signed difference, its magnitude, and updates the statistics.
REQ-026 SHALL make a sample accepted at edge t visible on the statistics outputs after edge t+2.
REQ-027 SHALL saturate n_samples, n_mismatch and sum_ed at their all-ones values, with no wrap-around.
REQ-028 SHALL update max_ed, max_a and max_b only when the error distance is strictly greater than max_ed.
REQ-029 SHALL, when stop and an accepted sample occur in the same cycle, count that sample and then enter DRAIN.
REQ-030 SHALL hold the statistics stable in DONE until the next start.

Reset
REQ-031 SHALL, while rst_n is low, force the FSM to IDLE, clear both pipeline valid bits, and drive every output to 0 (in_ready, busy, done, all statistics), including in the middle of a run.

Configuration
REQ-032 SHALL, when macro ERR_BIAS_EN is defined, add output sum_bias (signed, SUM_W) holding the saturating signed sum of (p_approx - a*b), cleared on start and reset.
REQ-033 SHALL, when ERR_BIAS_EN is not defined, not include the sum_bias port or its logic.

Structure
REQ-034 SHALL place the FSM state enum, default widths and the error-distance width constant (17) in package mult_err_pkg.
REQ-035 SHALL implement stage 2 as one sub-module, err_accum: difference, magnitude, saturating accumulate and max tracking.

Verification
REQ-036 SHALL test cfg_num=1 with a=12, b=15, p=180 -> done; n_samples=1, n_mismatch=0, sum_ed=0, max_ed=0.
REQ-037 SHALL test cfg_num=2 with (100,200,19872) then (255,255,65025) -> n_mismatch=1, sum_ed=128, max_ed=128, max_a=100, max_b=200; sum_bias=-128 when ERR_BIAS_EN is defined.
REQ-038 SHALL test stop in the same cycle as the 3rd accepted sample (cfg_num=0) -> n_samples=3, done two or more cycles later.
REQ-039 SHALL test preload of sum_ed near all-ones by forced samples with ed=65535 -> sum_ed stays at all-ones with no wrap.
REQ-040 SHALL test rst_n low mid-RUN -> all outputs 0 and FSM in IDLE; a following start gives a clean run.
REQ-041 SHALL test in_valid held low for 5 cycles in RUN -> statistics unchanged and in_ready stays high.

Source files
------------

// File: rtl/mult_err_monitor_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
// Optional feature macro used by the block: ERR_BIAS_EN (signed bias sum).
package mult_err_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned SUM_W_DEF = 40;
  // Signed difference of two 16-bit products needs one extra bit.
  localparam int unsigned ED_W      = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mult_err_monitor_err_accum.sv
// Stage 2 of the monitor: error difference, magnitude, saturating statistics
// and max tracking. ERR_BIAS_EN adds a saturating signed sum of differences.
module err_accum
  import mult_err_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      prod,
  input  logic [15:0]      p,
  output logic             s2_valid,
  output logic [CNT_W-1:0] n_samples,
  output logic [CNT_W-1:0] n_mismatch,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
`ifdef ERR_BIAS_EN
  ,
  output logic signed [SUM_W-1:0] sum_bias
`endif
);

  logic [ED_W-1:0]  diff;
  logic [ED_W-1:0]  diff_neg;
  logic [15:0]      ed;
  logic [SUM_W:0]   sum_add;

  // Two's-complement difference and its magnitude (always fits in 16 bits).
  always_comb begin
    diff     = {1'b0, p} - {1'b0, prod};
    diff_neg = '0 - diff;
    ed       = diff[ED_W-1] ? diff_neg[15:0] : diff[15:0];
    sum_add  = {1'b0, sum_ed} + (SUM_W+1)'(ed);
  end

`ifdef ERR_BIAS_EN
  logic signed [ED_W-1:0]  diff_s;
  logic signed [SUM_W-1:0] diff_ext;
  logic [SUM_W-1:0]        bias_add;
  logic [SUM_W-1:0]        bias_next;

  // Signed accumulate; overflow when operand signs agree but the result flips.
  always_comb begin
    diff_s    = diff;
    diff_ext  = SUM_W'(diff_s);
    bias_add  = sum_bias + diff_ext;
    bias_next = bias_add;
    if ((sum_bias[SUM_W-1] == diff_ext[SUM_W-1]) &&
        (bias_add[SUM_W-1] != sum_bias[SUM_W-1])) begin
      bias_next = sum_bias[SUM_W-1] ? {1'b1, {(SUM_W-1){1'b0}}}
                                    : {1'b0, {(SUM_W-1){1'b1}}};
    end
  end

  // Bias register: cleared on run start, updated per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_bias <= '0;
    end else if (clear) begin
      sum_bias <= '0;
    end else if (valid) begin
      sum_bias <= bias_next;
    end
  end
`endif

  // Statistics registers with saturating counters and strict-greater max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      n_samples  <= '0;
      n_mismatch <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else begin
      s2_valid <= valid && !clear;
      if (clear) begin
        n_samples  <= '0;
        n_mismatch <= '0;
        sum_ed     <= '0;
        max_ed     <= '0;
        max_a      <= '0;
        max_b      <= '0;
      end else if (valid) begin
        if (n_samples != '1) n_samples <= n_samples + CNT_W'(1);
        if ((ed != '0) && (n_mismatch != '1)) n_mismatch <= n_mismatch + CNT_W'(1);
        sum_ed <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
        if (ed > max_ed) begin
          max_ed <= ed;
          max_a  <= a;
          max_b  <= b;
        end
      end
    end
  end

endmodule

// File: rtl/mult_err_monitor.sv
// Error-statistics monitor for an approximate 8x8 multiplier.
// Stage 1 registers the exact product; stage 2 (err_accum) updates statistics.
// Optional macro ERR_BIAS_EN adds the signed sum_bias output.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_num,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      p_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] n_samples,
  output logic [CNT_W-1:0] n_mismatch,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
`ifdef ERR_BIAS_EN
  ,
  output logic signed [SUM_W-1:0] sum_bias
`endif
);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             run_start;
  logic             last_sample;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic             s2_valid;
  logic [7:0]       s1_a;
  logic [7:0]       s1_b;
  logic [15:0]      s1_prod;
  logic [15:0]      s1_p;

  assign in_ready    = (state == ST_RUN);
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign done        = (state == ST_DONE);
  assign accept      = in_valid && in_ready;
  assign run_start   = start && ((state == ST_IDLE) || (state == ST_DONE));
  // acc_cnt counts acceptances ahead of n_samples so the last one is known on the spot.
  assign last_sample = accept && (cfg_num != '0) && (acc_cnt == cfg_num - CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start only from IDLE/DONE, stop only in RUN.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (stop || last_sample) state_next = ST_DRAIN;
      ST_DRAIN: if (!s1_valid && !s2_valid) state_next = ST_DONE;
      ST_DONE:  if (start) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Accepted-sample counter used for the cfg_num end condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (run_start) begin
      acc_cnt <= '0;
    end else if (accept && (acc_cnt != '1)) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Stage 1: capture operands, product under test and exact product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prod  <= '0;
      s1_p     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_prod <= {8'b0, a} * {8'b0, b};
        s1_p    <= p_approx;
      end
    end
  end

  err_accum #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (run_start),
    .valid      (s1_valid),
    .a          (s1_a),
    .b          (s1_b),
    .prod       (s1_prod),
    .p          (s1_p),
    .s2_valid   (s2_valid),
    .n_samples  (n_samples),
    .n_mismatch (n_mismatch),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .max_a      (max_a),
    .max_b      (max_b)
`ifdef ERR_BIAS_EN
    ,
    .sum_bias   (sum_bias)
`endif
  );

endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor; a second narrow instance exercises saturation.
module tb_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_num = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] p_approx = '0;

  logic        in_ready, busy, done;
  logic [31:0] n_samples, n_mismatch;
  logic [39:0] sum_ed;
  logic [15:0] max_ed;
  logic [7:0]  max_a, max_b;
`ifdef ERR_BIAS_EN
  logic signed [39:0] sum_bias;
  logic signed [16:0] sum_bias2;
`endif

  logic        start2 = 1'b0;
  logic        stop2 = 1'b0;
  logic [1:0]  cfg2 = '0;
  logic        in_ready2, busy2, done2;
  logic [1:0]  n_samples2, n_mismatch2;
  logic [16:0] sum_ed2;
  logic [15:0] max_ed2;
  logic [7:0]  max_a2, max_b2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mult_err_monitor u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cfg_num    (cfg_num),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .p_approx   (p_approx),
    .busy       (busy),
    .done       (done),
    .n_samples  (n_samples),
    .n_mismatch (n_mismatch),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .max_a      (max_a),
`ifdef ERR_BIAS_EN
    .sum_bias   (sum_bias),
`endif
    .max_b      (max_b)
  );

  mult_err_monitor #(
    .CNT_W (2),
    .SUM_W (17)
  ) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .stop       (stop2),
    .cfg_num    (cfg2),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .a          (a),
    .b          (b),
    .p_approx   (p_approx),
    .busy       (busy2),
    .done       (done2),
    .n_samples  (n_samples2),
    .n_mismatch (n_mismatch2),
    .sum_ed     (sum_ed2),
    .max_ed     (max_ed2),
    .max_a      (max_a2),
`ifdef ERR_BIAS_EN
    .sum_bias   (sum_bias2),
`endif
    .max_b      (max_b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic send(input logic [7:0] sa, input logic [7:0] sb,
                      input logic [15:0] sp, input logic with_stop);
    in_valid = 1'b1;
    a        = sa;
    b        = sb;
    p_approx = sp;
    stop     = with_stop;
    tick();
    in_valid = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic begin_run(input logic [31:0] n);
    cfg_num = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !done; i++) tick();
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_nsamp", 64'(n_samples), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // cfg_num=1, exact product
    begin_run(32'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready", 64'(in_ready), 64'd1);
    send(8'd12, 8'd15, 16'd180, 1'b0);
    check("t1_drain_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    check("t1_latency", 64'(n_samples), 64'd1);
    wait_done("t1_done");
    check("t1_nsamp", 64'(n_samples), 64'd1);
    check("t1_nmis", 64'(n_mismatch), 64'd0);
    check("t1_sum", 64'(sum_ed), 64'd0);
    check("t1_max", 64'(max_ed), 64'd0);

    // cfg_num=2, one mismatch of -128, restart from DONE clears stats
    begin_run(32'd2);
    check("t2_clear", 64'(n_samples), 64'd0);
    send(8'd100, 8'd200, 16'd19872, 1'b0);
    send(8'd255, 8'd255, 16'd65025, 1'b0);
    wait_done("t2_done");
    check("t2_nsamp", 64'(n_samples), 64'd2);
    check("t2_nmis", 64'(n_mismatch), 64'd1);
    check("t2_sum", 64'(sum_ed), 64'd128);
    check("t2_max", 64'(max_ed), 64'd128);
    check("t2_max_a", 64'(max_a), 64'd100);
    check("t2_max_b", 64'(max_b), 64'd200);
`ifdef ERR_BIAS_EN
    check("t2_bias", sum_bias, -40'sd128);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stop_in_done", 64'(done), 64'd1);
    check("t2_hold", 64'(n_samples), 64'd2);

    // cfg_num=0, idle gap, stop with the 3rd sample, start ignored in DRAIN
    begin_run(32'd0);
    send(8'd3, 8'd4, 16'd12, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_gap_ready", 64'(in_ready), 64'd1);
    end
    check("t3_gap_nsamp", 64'(n_samples), 64'd1);
    check("t3_gap_sum", 64'(sum_ed), 64'd0);
    send(8'd2, 8'd2, 16'd5, 1'b0);
    send(8'd10, 8'd10, 16'd90, 1'b1);
    check("t3_stop_ready", 64'(in_ready), 64'd0);
    check("t3_stop_busy", 64'(busy), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_not_done_yet", 64'(done), 64'd0);
    wait_done("t3_done");
    check("t3_nsamp", 64'(n_samples), 64'd3);
    check("t3_nmis", 64'(n_mismatch), 64'd2);
    check("t3_sum", 64'(sum_ed), 64'd11);
    check("t3_max", 64'(max_ed), 64'd10);
    check("t3_max_a", 64'(max_a), 64'd10);
    check("t3_max_b", 64'(max_b), 64'd10);
`ifdef ERR_BIAS_EN
    check("t3_bias", sum_bias, -40'sd9);
`endif

    // Reset in the middle of a run, then a clean run
    begin_run(32'd0);
    send(8'd1, 8'd1, 16'd2, 1'b0);
    send(8'd2, 8'd3, 16'd7, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_rst_ready", 64'(in_ready), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_done", 64'(done), 64'd0);
    check("t4_rst_nsamp", 64'(n_samples), 64'd0);
    check("t4_rst_nmis", 64'(n_mismatch), 64'd0);
    check("t4_rst_sum", 64'(sum_ed), 64'd0);
    check("t4_rst_max", 64'(max_ed), 64'd0);
    check("t4_rst_max_a", 64'(max_a), 64'd0);
    check("t4_rst_max_b", 64'(max_b), 64'd0);
`ifdef ERR_BIAS_EN
    check("t4_rst_bias", sum_bias, 40'sd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_idle", 64'(busy), 64'd0);
    begin_run(32'd1);
    send(8'd7, 8'd9, 16'd63, 1'b0);
    wait_done("t4_done");
    check("t4_nsamp", 64'(n_samples), 64'd1);
    check("t4_nmis", 64'(n_mismatch), 64'd0);
    check("t4_sum", 64'(sum_ed), 64'd0);

    // Saturation on the narrow instance: four samples with ed=65535
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    in_valid = 1'b1;
    a = 8'd0;
    b = 8'd5;
    p_approx = 16'hFFFF;
    tick(); tick(); tick();
    stop2 = 1'b1;
    tick();
    stop2 = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !done2; i++) tick();
    check("t5_done", 64'(done2), 64'd1);
    check("t5_sum_sat", 64'(sum_ed2), 64'h1FFFF);
    check("t5_nsamp_sat", 64'(n_samples2), 64'd3);
    check("t5_nmis_sat", 64'(n_mismatch2), 64'd3);
    check("t5_max", 64'(max_ed2), 64'hFFFF);
    check("t5_max_a", 64'(max_a2), 64'd0);
    check("t5_max_b", 64'(max_b2), 64'd5);
`ifdef ERR_BIAS_EN
    check("t5_bias_sat", sum_bias2, 17'sd65535);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
